// File: rtl/tstate_decoder.sv
// tstate_decoder: variable-length one-hot T-state ring, opcode IR and one-hot
// instruction decode with halt latch.
module tstate_decoder #(
    parameter int OPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [OPW-1:0] mdr_data,
    input  logic           ir_inen,
    output logic [11:0]    t,
    output logic [32:0]    dec,
    output logic [OPW-1:0] ir,
    output logic           halted
);
    logic [11:0]    t_q, t_d;
    logic [OPW-1:0] ir_q, ir_d;
    logic           halted_q, halted_d;
    logic [31:0]    op;
    logic [3:0]     last_st;
    logic           one_hot, adv, hlt_now, wrap;

    assign op  = 32'(ir_q);
    assign dec = (op <= 32) ? 33'd1 << ir_q : 33'd1;

    always_comb begin
        last_st  = op == 3 ? 4'd4 : (op >= 12 && op <= 15) ? 4'd5 : op == 7 ? 4'd10 : op == 6 ? 4'd11 : 4'd3;
        one_hot  = t_q != 12'd0 && (t_q & (t_q - 12'd1)) == 12'd0;
        adv      = run && !halted_q;
        hlt_now  = adv && t_q == 12'h008 && dec[32];
        // wrap once at or past the last state, so an IR change mid-instruction cannot run off the ring
        wrap     = |(t_q >> last_st);
        t_d      = !one_hot ? 12'h001 : (!adv || hlt_now) ? t_q : wrap ? 12'h001 : t_q << 1;
        ir_d     = (adv && ir_inen) ? mdr_data : ir_q;
        halted_d = halted_q || hlt_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q      <= 12'h001;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    assign t      = t_q;
    assign ir     = ir_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_tstate_decoder.sv
// tb_tstate_decoder: directed stimulus with a cycle-level reference model of the
// T-state sequencer and literal checkpoints along each instruction.
module tb_tstate_decoder;
    logic        clk, rst, run, ir_inen;
    logic [7:0]  mdr_data;
    logic [11:0] t;
    logic [32:0] dec;
    logic [7:0]  ir;
    logic        halted;

    int   total = 0, bad = 0;
    bit   chk_en = 0;
    int   m_t = 0;
    logic [7:0] m_ir = 8'h00;
    bit   m_h = 0;

    tstate_decoder #(.OPW(8)) dut (
        .clk(clk), .rst(rst), .run(run), .mdr_data(mdr_data), .ir_inen(ir_inen),
        .t(t), .dec(dec), .ir(ir), .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int last_of(logic [7:0] op);
        case (op)
            8'h03:                      return 4;
            8'h0C, 8'h0D, 8'h0E, 8'h0F: return 5;
            8'h07:                      return 10;
            8'h06:                      return 11;
            default:                    return 3;
        endcase
    endfunction

    function automatic logic [32:0] exp_dec(logic [7:0] op);
        logic [32:0] d;
        d = '0;
        if (int'(op) <= 32) d[int'(op)] = 1'b1;
        else d[0] = 1'b1;
        return d;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_ir = 8'h00; m_h = 0;
        end else if (run && !m_h) begin
            if (m_t == 3 && m_ir == 8'h20) m_h = 1;
            else if (m_t >= last_of(m_ir)) m_t = 0;
            else m_t++;
            if (ir_inen) m_ir = mdr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("mdl_t", 64'(t), 64'(12'(1) << m_t));
            chk("mdl_dec", 64'(dec), 64'(exp_dec(m_ir)));
            chk("mdl_ir", 64'(ir), 64'(m_ir));
            chk("mdl_halted", 64'(halted), 64'(m_h));
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fetch(logic [7:0] op);
        int i;
        for (i = 0; i < 20 && t !== 12'h004; i++) @(negedge clk);
        if (t !== 12'h004) chk("fetch_t2_timeout", 64'(t), 64'h004);
        ir_inen = 1; mdr_data = op;
        @(negedge clk);
        ir_inen = 0;
    endtask

    initial begin
        run = 0; ir_inen = 0; mdr_data = 8'h00; rst = 0;
        #1 rst = 1;
        #3;
        chk("rst_t", 64'(t), 64'h001);
        chk("rst_ir", 64'(ir), 64'h00);
        chk("rst_dec", 64'(dec), 64'h1);
        chk("rst_halted", 64'(halted), 64'h0);
        @(negedge clk);
        rst = 0; run = 1; chk_en = 1;
        step(1); chk("nop_t1", 64'(t), 64'h002);
        step(1); chk("nop_t2", 64'(t), 64'h004);
        step(1); chk("nop_t3", 64'(t), 64'h008);
        step(1); chk("nop_wrap", 64'(t), 64'h001);
        fetch(8'h03);
        chk("add_dec", 64'(dec), 64'h8);
        chk("add_t3", 64'(t), 64'h008);
        step(1); chk("add_t4", 64'(t), 64'h010);
        step(1); chk("add_wrap", 64'(t), 64'h001);
        fetch(8'h07);
        step(7); chk("mul_t10", 64'(t), 64'h400);
        step(1); chk("mul_wrap", 64'(t), 64'h001);
        fetch(8'h06);
        step(8); chk("div_t11", 64'(t), 64'h800);
        step(1); chk("div_wrap", 64'(t), 64'h001);
        fetch(8'h0D);
        chk("jz_dec", 64'(dec), 64'h2000);
        step(2); chk("jz_t5", 64'(t), 64'h020);
        step(1); chk("jz_wrap", 64'(t), 64'h001);
        fetch(8'hFF);
        chk("undef_dec", 64'(dec), 64'h1);
        chk("undef_ir", 64'(ir), 64'hFF);
        step(1); chk("undef_wrap", 64'(t), 64'h001);
        fetch(8'h07);
        step(4); chk("stall_t7", 64'(t), 64'h080);
        run = 0; ir_inen = 1; mdr_data = 8'h00;
        step(5);
        chk("stall_hold_t", 64'(t), 64'h080);
        chk("stall_hold_ir", 64'(ir), 64'h07);
        ir_inen = 0; run = 1;
        step(3); chk("stall_t10", 64'(t), 64'h400);
        step(1); chk("stall_wrap", 64'(t), 64'h001);
        fetch(8'h03);
        ir_inen = 1; mdr_data = 8'h0C;
        step(1); ir_inen = 0;
        chk("late_load_ir", 64'(ir), 64'h0C);
        chk("late_load_t", 64'(t), 64'h010);
        step(1); chk("late_load_t5", 64'(t), 64'h020);
        step(1); chk("late_load_wrap", 64'(t), 64'h001);
        fetch(8'h06);
        step(1); chk("div_t4", 64'(t), 64'h010);
        #2 rst = 1;
        #1;
        chk("arst_t", 64'(t), 64'h001);
        chk("arst_ir", 64'(ir), 64'h00);
        chk("arst_dec", 64'(dec), 64'h1);
        #1 rst = 0;
        @(negedge clk); chk("arst_resume", 64'(t), 64'h002);
        fetch(8'h20);
        chk("hlt_dec", 64'(dec), 64'h1_0000_0000);
        step(1);
        chk("hlt_halted", 64'(halted), 64'h1);
        chk("hlt_t", 64'(t), 64'h008);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom); ir_inen = 1; mdr_data = 8'h03;
            step(1);
        end
        chk("hlt_hold_t", 64'(t), 64'h008);
        chk("hlt_hold_halted", 64'(halted), 64'h1);
        chk("hlt_hold_ir", 64'(ir), 64'h20);
        run = 1; ir_inen = 0;
        #2 rst = 1;
        #1;
        chk("hlt_rst_t", 64'(t), 64'h001);
        chk("hlt_rst_halted", 64'(halted), 64'h0);
        #1 rst = 0;
        step(2); chk("post_hlt_t2", 64'(t), 64'h004);
        step(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
